// File: rtl/wb_core_2_pkg.sv
// Shared widths, FSM encoding, request record and access-legality decode
// for the core-2 Wishbone register slave.
package wb_core_2_pkg;

    localparam int ADDR_WIDTH   = 16;
    localparam int DATA_WIDTH   = 32;
    localparam int GRANULE      = 8;
    localparam int REGISTER_NUM = 16;
    localparam int SEL_WIDTH    = DATA_WIDTH / GRANULE;
    localparam int WORD_LSB     = $clog2(SEL_WIDTH);
    localparam int INDEX_WIDTH  = $clog2(REGISTER_NUM);
    localparam int WIDX_WIDTH   = ADDR_WIDTH - WORD_LSB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] adr;
        logic                  we;
        logic [SEL_WIDTH-1:0]  sel;
        logic [DATA_WIDTH-1:0] dat;
    } req_t;

    // Out-of-range word, misaligned byte address or empty lane mask all terminate with err.
    function automatic logic req_illegal(input req_t req);
        logic [WIDX_WIDTH-1:0] word_idx;
        logic                  out_of_range;
        logic                  misaligned;
        logic                  no_lanes;
        word_idx     = req.adr[ADDR_WIDTH-1:WORD_LSB];
        out_of_range = (word_idx >= WIDX_WIDTH'(REGISTER_NUM));
        misaligned   = (req.adr[WORD_LSB-1:0] != {WORD_LSB{1'b0}});
        no_lanes     = (req.sel == {SEL_WIDTH{1'b0}});
        return out_of_range | misaligned | no_lanes;
    endfunction

endpackage

// File: rtl/wb_core_2_slave_reg_bank.sv
// Byte-enable register array: synchronous clear, one lane-masked write port,
// one combinational read port.
module wb_reg_bank
    import wb_core_2_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_idx,
    input  logic [SEL_WIDTH-1:0]   wr_sel,
    input  logic [DATA_WIDTH-1:0]  wr_dat,
    input  logic [INDEX_WIDTH-1:0] rd_idx,
    output logic [DATA_WIDTH-1:0]  rd_dat
);

    logic [DATA_WIDTH-1:0] mem_r [REGISTER_NUM];

    // Clear on reset, otherwise update only the enabled byte lanes of the addressed word
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGISTER_NUM; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wr_en) begin
            for (int b = 0; b < SEL_WIDTH; b++) begin
                if (wr_sel[b]) begin
                    mem_r[wr_idx][b*GRANULE +: GRANULE] <= wr_dat[b*GRANULE +: GRANULE];
                end
            end
        end
    end

    assign rd_dat = mem_r[rd_idx];

endmodule

// File: rtl/wb_core_2_slave.sv
// Wishbone B4 pipelined slave in front of the core-2 register bank, with
// optional wait states and error termination of illegal accesses.
module wb_core_2_slave
    import wb_core_2_pkg::*;
#(
    parameter int WAIT_STATES = 0
)
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  stall_o
);

    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t                state_r;
    logic [3:0]            cnt_r;
    req_t                  req_r;
    logic                  ack_r;
    logic                  err_r;
    logic                  stall_r;
    logic [DATA_WIDTH-1:0] dat_r;

    req_t                  bus_req_s;
    req_t                  resp_req_s;
    logic                  accept_s;
    logic                  respond_s;
    logic                  illegal_s;
    logic                  wr_en_s;
    logic [DATA_WIDTH-1:0] rd_dat_s;

    assign bus_req_s.adr = adr_i;
    assign bus_req_s.we  = we_i;
    assign bus_req_s.sel = sel_i;
    assign bus_req_s.dat = dat_i;

    // Pick the request being answered at this edge: live bus with no wait states, captured one after WAIT
    always_comb begin
        accept_s   = 1'b0;
        respond_s  = 1'b0;
        resp_req_s = bus_req_s;
        case (state_r)
            IDLE, RESP: begin
                accept_s = cyc_i & stb_i & ~stall_r;
                if (WAIT_STATES == 0) begin
                    respond_s = cyc_i & stb_i & ~stall_r;
                end else begin
                    respond_s = 1'b0;
                end
                resp_req_s = bus_req_s;
            end
            WAIT: begin
                accept_s   = 1'b0;
                respond_s  = cyc_i & (cnt_r == 4'd0);
                resp_req_s = req_r;
            end
            default: begin
                accept_s   = 1'b0;
                respond_s  = 1'b0;
                resp_req_s = bus_req_s;
            end
        endcase
        illegal_s = req_illegal(resp_req_s);
        wr_en_s   = respond_s & resp_req_s.we & ~illegal_s;
    end

    wb_reg_bank u_reg_bank (
        .clk    (clk_i),
        .rst    (rst_i),
        .wr_en  (wr_en_s),
        .wr_idx (resp_req_s.adr[WORD_LSB +: INDEX_WIDTH]),
        .wr_sel (resp_req_s.sel),
        .wr_dat (resp_req_s.dat),
        .rd_idx (resp_req_s.adr[WORD_LSB +: INDEX_WIDTH]),
        .rd_dat (rd_dat_s)
    );

    // FSM, wait counter and registered bus outputs; an aborted WAIT drops the request silently
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            req_r   <= {$bits(req_t){1'b0}};
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            stall_r <= 1'b0;
            dat_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            ack_r <= respond_s & ~illegal_s;
            err_r <= respond_s & illegal_s;
            dat_r <= (respond_s & ~illegal_s & ~resp_req_s.we) ? rd_dat_s : {DATA_WIDTH{1'b0}};
            case (state_r)
                IDLE, RESP: begin
                    if (accept_s) begin
                        req_r <= bus_req_s;
                        if (WAIT_STATES == 0) begin
                            state_r <= RESP;
                            stall_r <= 1'b0;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= WS_INIT;
                            stall_r <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                        stall_r <= 1'b0;
                    end
                end
                WAIT: begin
                    if (!cyc_i) begin
                        state_r <= IDLE;
                        stall_r <= 1'b0;
                    end else if (cnt_r == 4'd0) begin
                        state_r <= RESP;
                        stall_r <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r - 4'd1;
                        stall_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    stall_r <= 1'b0;
                end
            endcase
        end
    end

    assign dat_o   = dat_r;
    assign ack_o   = ack_r;
    assign err_o   = err_r;
    assign stall_o = stall_r;

endmodule
